// File: rtl/axi_adc_jesd204_pnstat.sv
// PN-monitor status accumulator: lock FSM, saturating error/loss counters and
// sticky error/timeout flags, all in the adc_clk domain.
module axi_adc_jesd204_pnstat #(
    parameter int unsigned ERR_CNT_WIDTH  = 32,
    parameter int unsigned LOSS_CNT_WIDTH = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                      adc_clk,
    input  logic                      adc_rst,
    input  logic                      adc_pn_oos,
    input  logic                      adc_pn_err,
    input  logic [3:0]                adc_pnseq_sel,
    input  logic                      adc_pnstat_clr,
    output logic [1:0]                adc_pnstat_state,
    output logic                      adc_pn_locked,
    output logic [ERR_CNT_WIDTH-1:0]  adc_pn_err_count,
    output logic [LOSS_CNT_WIDTH-1:0] adc_pn_loss_count,
    output logic                      adc_pn_err_sticky,
    output logic                      adc_pn_timeout
);

    typedef enum logic [1:0] {
        StSearch  = 2'd0,
        StLocked  = 2'd1,
        StLost    = 2'd2,
        StTimeout = 2'd3
    } state_e;

    localparam logic [23:0] TimerLast = 24'(TIMEOUT_CYCLES - 1);

    state_e                    state_q, state_d;
    logic [23:0]               timer_q, timer_d;
    logic [3:0]                seq_q;
    logic [ERR_CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
    logic [LOSS_CNT_WIDTH-1:0] loss_cnt_q, loss_cnt_d;
    logic                      err_sticky_q, err_sticky_d;
    logic                      timeout_q, timeout_d;
    logic                      restart;

    assign restart = (adc_pnseq_sel != seq_q);

    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            state_q      <= StSearch;
            timer_q      <= '0;
            seq_q        <= '0;
            err_cnt_q    <= '0;
            loss_cnt_q   <= '0;
            err_sticky_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            seq_q        <= adc_pnseq_sel;
            err_cnt_q    <= err_cnt_d;
            loss_cnt_q   <= loss_cnt_d;
            err_sticky_q <= err_sticky_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        err_cnt_d    = err_cnt_q;
        loss_cnt_d   = loss_cnt_q;
        err_sticky_d = err_sticky_q;
        timeout_d    = timeout_q;
        if (adc_pnstat_clr) begin
            state_d      = StSearch;
            timer_d      = '0;
            err_cnt_d    = '0;
            loss_cnt_d   = '0;
            err_sticky_d = 1'b0;
            timeout_d    = 1'b0;
        end else if (restart) begin
            // Sequence change: relock from scratch but keep the statistics.
            state_d = StSearch;
            timer_d = '0;
        end else begin
            unique case (state_q)
                StSearch, StLost: begin
                    if (!adc_pn_oos) begin
                        state_d = StLocked;
                        timer_d = '0;
                    end else if (timer_q == TimerLast) begin
                        state_d   = StTimeout;
                        timeout_d = 1'b1;
                    end else begin
                        timer_d = timer_q + 24'd1;
                    end
                end
                StLocked: begin
                    if (adc_pn_err) begin
                        err_sticky_d = 1'b1;
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                    end
                    if (adc_pn_oos) begin
                        state_d = StLost;
                        timer_d = '0;
                        if (loss_cnt_q != '1) loss_cnt_d = loss_cnt_q + 1'b1;
                    end
                end
                StTimeout: begin
                    if (!adc_pn_oos) begin
                        state_d = StLocked;
                        timer_d = '0;
                    end
                end
                default: state_d = StSearch;
            endcase
        end
    end

    always_comb begin
        adc_pnstat_state  = state_q;
        adc_pn_locked     = (state_q == StLocked);
        adc_pn_err_count  = err_cnt_q;
        adc_pn_loss_count = loss_cnt_q;
        adc_pn_err_sticky = err_sticky_q;
        adc_pn_timeout    = timeout_q;
    end

endmodule

// File: tb/tb_axi_adc_jesd204_pnstat.sv
// Directed bench for axi_adc_jesd204_pnstat with small widths and a short timeout.
module tb_axi_adc_jesd204_pnstat;

    localparam int unsigned EW = 4;
    localparam int unsigned LW = 2;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst, oos, err, clr;
    logic [3:0]    sel;
    logic [1:0]    state;
    logic          locked, sticky, tmo;
    logic [EW-1:0] err_cnt;
    logic [LW-1:0] loss_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    axi_adc_jesd204_pnstat #(
        .ERR_CNT_WIDTH (EW),
        .LOSS_CNT_WIDTH(LW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .adc_clk          (clk),
        .adc_rst          (rst),
        .adc_pn_oos       (oos),
        .adc_pn_err       (err),
        .adc_pnseq_sel    (sel),
        .adc_pnstat_clr   (clr),
        .adc_pnstat_state (state),
        .adc_pn_locked    (locked),
        .adc_pn_err_count (err_cnt),
        .adc_pn_loss_count(loss_cnt),
        .adc_pn_err_sticky(sticky),
        .adc_pn_timeout   (tmo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic [31:0] ec,
                           input logic [31:0] lc, input logic sk, input logic to);
        chk({tag, "_state"}, 32'(state), 32'(st));
        chk({tag, "_locked"}, 32'(locked), 32'(st == 2'd1));
        chk({tag, "_err_cnt"}, 32'(err_cnt), ec);
        chk({tag, "_loss_cnt"}, 32'(loss_cnt), lc);
        chk({tag, "_sticky"}, 32'(sticky), 32'(sk));
        chk({tag, "_timeout"}, 32'(tmo), 32'(to));
    endtask

    initial begin
        rst = 1'b1; oos = 1'b1; err = 1'b0; clr = 1'b0; sel = 4'd0;
        step();
        step();
        chk_all("reset", 2'd0, 0, 0, 1'b0, 1'b0);

        // Search with errors present: errors must be ignored
        rst = 1'b0; err = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("search", 2'd0, 0, 0, 1'b0, 1'b0);
        end
        err = 1'b0; oos = 1'b0;
        step();
        chk_all("lock", 2'd1, 0, 0, 1'b0, 1'b0);

        err = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk_all("err5", 2'd1, 5, 0, 1'b1, 1'b0);
        err = 1'b0; oos = 1'b1;
        step();
        chk_all("lost", 2'd2, 5, 1, 1'b1, 1'b0);
        oos = 1'b0;
        step();
        chk_all("relock", 2'd1, 5, 1, 1'b1, 1'b0);

        // Timeout from reset with oos held high
        rst = 1'b1; oos = 1'b1;
        step();
        chk_all("reset2", 2'd0, 0, 0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("to_wait_state", 32'(state), 32'd0);
        end
        step();
        chk_all("timeout", 2'd3, 0, 0, 1'b0, 1'b1);
        step();
        chk("timeout_hold", 32'(state), 32'd3);
        oos = 1'b0;
        step();
        chk_all("to_relock", 2'd1, 0, 0, 1'b0, 1'b1);

        // Saturation of both counters
        err = 1'b1;
        for (int i = 0; i < 15; i++) step();
        chk("err_at15", 32'(err_cnt), 32'd15);
        for (int i = 0; i < 5; i++) step();
        chk("err_sat", 32'(err_cnt), 32'd15);
        err = 1'b0;
        for (int i = 0; i < 5; i++) begin
            oos = 1'b1; step();
            oos = 1'b0; step();
        end
        chk_all("loss_sat", 2'd1, 15, 3, 1'b1, 1'b1);

        // Restart on sequence change drops the same-cycle error
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk_all("clr1", 2'd0, 0, 0, 1'b0, 1'b0);
        step();
        chk("clr1_lock", 32'(state), 32'd1);
        err = 1'b1;
        for (int i = 0; i < 7; i++) step();
        chk("err7", 32'(err_cnt), 32'd7);
        sel = 4'd1;
        step();
        chk_all("restart", 2'd0, 7, 0, 1'b1, 1'b0);
        err = 1'b0; oos = 1'b1; clr = 1'b1;
        step();
        clr = 1'b0;
        chk_all("clr2", 2'd0, 0, 0, 1'b0, 1'b0);

        // Error and loss counted together on the LOCKED->LOST edge
        oos = 1'b0;
        step();
        err = 1'b1;
        step();
        step();
        oos = 1'b1;
        step();
        chk_all("err_and_loss", 2'd2, 3, 1, 1'b1, 1'b0);
        oos = 1'b0; err = 1'b0;
        step();
        chk("relock2", 32'(state), 32'd1);
        clr = 1'b1; oos = 1'b1; err = 1'b1;
        step();
        clr = 1'b0;
        chk_all("clr_prio", 2'd0, 0, 0, 1'b0, 1'b0);

        // Reset mid-LOCKED overrides everything
        oos = 1'b0; err = 1'b0;
        step();
        err = 1'b1;
        step();
        chk_all("pre_rst", 2'd1, 1, 0, 1'b1, 1'b0);
        rst = 1'b1; oos = 1'b1; sel = 4'd5; clr = 1'b0;
        step();
        chk_all("mid_rst", 2'd0, 0, 0, 1'b0, 1'b0);
        rst = 1'b0; err = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
